// File: rtl/block_ram_arbiter_pkg.sv
// rtl/block_ram_arbiter_pkg.sv - TileLink-UL channel types and opcodes shared by the RAM arbiter
package block_ram_arbiter_pkg;

  localparam logic [2:0] TL_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] TL_GET              = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA  = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic        d_error;
    logic [31:0] d_data;
  } tilelink_d;

  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] mask,
                                    input logic [31:0] tag);
    return (addr & mask) == tag;
  endfunction

endpackage

// File: rtl/block_ram_arbiter_rr_arb2.sv
// rtl/block_ram_arbiter_rr_arb2.sv - two-way round-robin / fixed-priority arbiter
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       fixed_priority,
  output logic [1:0] gnt
);

  // last_q resets to 1 so master 0 wins the first contention
  logic last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (fixed_priority || last_q) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else if (|gnt) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/block_ram_arbiter.sv
// rtl/block_ram_arbiter.sv - shares one block_ram between fetch and load/store masters
module block_ram_arbiter
  import block_ram_arbiter_pkg::*;
#(
  parameter logic [31:0] addr_mask      = 32'hF0000000,
  parameter logic [31:0] addr_tag       = 32'h00000000,
  parameter bit          fixed_priority = 1'b0
) (
  input  logic      clock,
  input  logic      reset_n,
  input  tilelink_a m0_tla,
  output tilelink_d m0_tld,
  input  tilelink_a m1_tla,
  output tilelink_d m1_tld,
  output tilelink_a ram_tla,
  input  tilelink_d ram_tld
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       grant;
  logic       hit;
  tilelink_a  sel_a;
  logic       own_valid_q;
  logic       own_id_q;
  logic       err_q;
  tilelink_d  rsp;
  logic       unused_ram_tld;

  // Gating with reset_n keeps grants off for the whole reset pulse, not just at edges
  assign req = {m1_tla.a_valid, m0_tla.a_valid} & {2{reset_n}};

  rr_arb2 u_arb (
    .clock          (clock),
    .reset_n        (reset_n),
    .req            (req),
    .fixed_priority (fixed_priority),
    .gnt            (gnt)
  );

  assign grant = |gnt;
  assign sel_a = gnt[1] ? m1_tla : m0_tla;
  assign hit   = addr_hit(sel_a.a_address, addr_mask, addr_tag);

  always_comb begin
    ram_tla         = sel_a;
    ram_tla.a_valid = grant & hit;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      own_valid_q <= 1'b0;
      own_id_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      own_valid_q <= grant;
      own_id_q    <= gnt[1];
      err_q       <= grant & ~hit;
    end
  end

  // Misses never reach the RAM, so their error response is synthesised here
  always_comb begin
    rsp = '0;
    if (err_q) begin
      rsp.d_valid  = 1'b1;
      rsp.d_error  = 1'b1;
      rsp.d_opcode = TL_ACCESS_ACK_DATA;
    end else begin
      rsp.d_valid  = ram_tld.d_valid;
      rsp.d_opcode = ram_tld.d_opcode;
      rsp.d_data   = ram_tld.d_data;
    end
  end

  always_comb begin
    m0_tld         = rsp;
    m1_tld         = rsp;
    m0_tld.d_valid = rsp.d_valid & own_valid_q & ~own_id_q;
    m1_tld.d_valid = rsp.d_valid & own_valid_q & own_id_q;
    m0_tld.d_error = rsp.d_error & own_valid_q & ~own_id_q;
    m1_tld.d_error = rsp.d_error & own_valid_q & own_id_q;
    m0_tld.d_ready = gnt[0];
    m1_tld.d_ready = gnt[1];
  end

  assign unused_ram_tld = ^{ram_tld.d_ready, ram_tld.d_error};

endmodule

// File: tb/tb_block_ram_arbiter.sv
// tb/tb_block_ram_arbiter.sv - directed scoreboard bench for block_ram_arbiter
module tb_block_ram_arbiter;
  import block_ram_arbiter_pkg::*;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic      clock;
  logic      reset_n;
  tilelink_a m0_tla, m1_tla, ram_tla, fp_ram_tla;
  tilelink_d m0_tld, m1_tld, ram_tld, fp_m0_tld, fp_m1_tld, fp_ram_tld;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  block_ram_arbiter u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .m0_tla  (m0_tla),
    .m0_tld  (m0_tld),
    .m1_tla  (m1_tla),
    .m1_tld  (m1_tld),
    .ram_tla (ram_tla),
    .ram_tld (ram_tld)
  );

  block_ram_arbiter #(.fixed_priority(1'b1)) u_dut_fp (
    .clock   (clock),
    .reset_n (reset_n),
    .m0_tla  (m0_tla),
    .m0_tld  (fp_m0_tld),
    .m1_tla  (m1_tla),
    .m1_tld  (fp_m1_tld),
    .ram_tla (fp_ram_tla),
    .ram_tld (fp_ram_tld)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = m[b] ? d[b*8 +: 8] : old[b*8 +: 8];
    return r;
  endfunction

  // Behavioural block_ram: registered, one-cycle latency, always ready
  always @(posedge clock) begin
    ram_tld.d_valid  <= ram_tla.a_valid;
    ram_tld.d_ready  <= 1'b1;
    ram_tld.d_error  <= 1'b0;
    ram_tld.d_opcode <= TL_ACCESS_ACK_DATA;
    if (ram_tla.a_valid) begin
      if (ram_tla.a_opcode == TL_GET) begin
        ram_tld.d_data <= mem[ram_tla.a_address[9:2]];
      end else begin
        mem[ram_tla.a_address[9:2]] <= merge(mem[ram_tla.a_address[9:2]], ram_tla.a_data, ram_tla.a_mask);
        ram_tld.d_data <= merge(mem[ram_tla.a_address[9:2]], ram_tla.a_data, ram_tla.a_mask);
      end
    end
    fp_ram_tld.d_valid  <= fp_ram_tla.a_valid;
    fp_ram_tld.d_ready  <= 1'b1;
    fp_ram_tld.d_error  <= 1'b0;
    fp_ram_tld.d_opcode <= TL_ACCESS_ACK_DATA;
    fp_ram_tld.d_data   <= 32'h0;
  end

  function automatic tilelink_a rd(input logic [31:0] addr);
    tilelink_a a = '0;
    a.a_valid = 1'b1; a.a_opcode = TL_GET; a.a_address = addr; a.a_mask = 4'hF;
    return a;
  endfunction

  function automatic tilelink_a wr(input logic [2:0] op, input logic [31:0] addr,
                                   input logic [31:0] data, input logic [3:0] mask);
    tilelink_a a = '0;
    a.a_valid = 1'b1; a.a_opcode = op; a.a_address = addr; a.a_data = data; a.a_mask = mask;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, check last cycle's response and this cycle's accept
  task automatic step(input tilelink_a a0, input tilelink_a a1, input logic [1:0] exp_gnt,
                      input logic exp_hit, input logic fp_chk, input logic [1:0] exp_fp_gnt);
    tilelink_d rsp, oth;
    tilelink_a ga;
    exp_t      e;
    logic [7:0] idx;
    m0_tla = a0;
    m1_tla = a1;
    @(negedge clock);
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      rsp = e.id ? m1_tld : m0_tld;
      oth = e.id ? m0_tld : m1_tld;
      chk("rsp_valid", 32'(rsp.d_valid), 32'd1);
      chk("rsp_data", rsp.d_data, e.data);
      chk("rsp_error", 32'(rsp.d_error), 32'(e.err));
      chk("rsp_opcode", 32'(rsp.d_opcode), 32'(TL_ACCESS_ACK_DATA));
      chk("other_valid", 32'(oth.d_valid), 32'd0);
    end else begin
      chk("idle_m0_valid", 32'(m0_tld.d_valid), 32'd0);
      chk("idle_m1_valid", 32'(m1_tld.d_valid), 32'd0);
    end
    chk("m0_ready", 32'(m0_tld.d_ready), 32'(exp_gnt[0]));
    chk("m1_ready", 32'(m1_tld.d_ready), 32'(exp_gnt[1]));
    chk("ram_valid", 32'(ram_tla.a_valid), 32'((|exp_gnt) & exp_hit));
    if (fp_chk) begin
      chk("fp_m0_ready", 32'(fp_m0_tld.d_ready), 32'(exp_fp_gnt[0]));
      chk("fp_m1_ready", 32'(fp_m1_tld.d_ready), 32'(exp_fp_gnt[1]));
    end
    if (|exp_gnt) begin
      ga  = exp_gnt[1] ? a1 : a0;
      idx = ga.a_address[9:2];
      e.id  = exp_gnt[1];
      e.err = ~exp_hit;
      if (!exp_hit) begin
        e.data = 32'h0;
      end else if (ga.a_opcode == TL_GET) begin
        e.data = ref_mem[idx];
      end else begin
        ref_mem[idx] = merge(ref_mem[idx], ga.a_data, ga.a_mask);
        e.data = ref_mem[idx];
      end
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hC0DE0000 + 32'(i);
      ref_mem[i] = 32'hC0DE0000 + 32'(i);
    end
    reset_n = 1'b0;
    m0_tla  = '0;
    m1_tla  = '0;
    repeat (2) @(posedge clock);
    #1;
    m0_tla = rd(32'h40);
    m1_tla = rd(32'h80);
    #1;
    chk("rst_m0_ready", 32'(m0_tld.d_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_tld.d_ready), 32'd0);
    chk("rst_ram_valid", 32'(ram_tla.a_valid), 32'd0);
    chk("rst_m0_valid", 32'(m0_tld.d_valid), 32'd0);
    chk("rst_m1_valid", 32'(m1_tld.d_valid), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Round-robin contention straight after reset: m0, m1, m0, m1
    for (int i = 0; i < 4; i++) step(rd(32'h40), rd(32'h80), (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0, 2'b00);
    step('0, '0, 2'b00, 1'b1, 1'b0, 2'b00);

    // Single master read
    step(rd(32'h10), '0, 2'b01, 1'b1, 1'b0, 2'b00);
    step('0, '0, 2'b00, 1'b1, 1'b0, 2'b00);

    // Fixed-priority instance: m0 always wins, m1 accepted once m0 drops
    step(rd(32'h44), rd(32'h84), 2'b10, 1'b1, 1'b1, 2'b01);
    step(rd(32'h44), rd(32'h84), 2'b01, 1'b1, 1'b1, 2'b01);
    step(rd(32'h44), rd(32'h84), 2'b10, 1'b1, 1'b1, 2'b01);
    step('0, rd(32'h84), 2'b10, 1'b1, 1'b1, 2'b10);
    step('0, '0, 2'b00, 1'b1, 1'b1, 2'b00);

    // Address miss answered locally, RAM untouched
    step('0, wr(TL_PUT_FULL_DATA, 32'h10000000, 32'hDEADBEEF, 4'hF), 2'b10, 1'b0, 1'b0, 2'b00);
    step('0, '0, 2'b00, 1'b1, 1'b0, 2'b00);
    chk("miss_ram_unchanged", mem[0], 32'hC0DE0000);

    // Back-to-back write then read of the same word
    step('0, wr(TL_PUT_PARTIAL_DATA, 32'h20, 32'hAABBCCDD, 4'hF), 2'b10, 1'b1, 1'b0, 2'b00);
    step(rd(32'h20), '0, 2'b01, 1'b1, 1'b0, 2'b00);
    step('0, '0, 2'b00, 1'b1, 1'b0, 2'b00);

    // Reset the cycle after a grant drops the in-flight response
    step(rd(32'h30), '0, 2'b01, 1'b1, 1'b0, 2'b00);
    reset_n = 1'b0;
    m0_tla  = rd(32'h30);
    m1_tla  = rd(32'h40);
    #1;
    chk("midrst_m0_valid", 32'(m0_tld.d_valid), 32'd0);
    chk("midrst_m1_valid", 32'(m1_tld.d_valid), 32'd0);
    chk("midrst_ram_valid", 32'(ram_tla.a_valid), 32'd0);
    chk("midrst_m0_ready", 32'(m0_tld.d_ready), 32'd0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(rd(32'h30), rd(32'h40), 2'b01, 1'b1, 1'b0, 2'b00);
    step(rd(32'h30), rd(32'h40), 2'b10, 1'b1, 1'b0, 2'b00);
    step('0, '0, 2'b00, 1'b1, 1'b0, 2'b00);
    step('0, '0, 2'b00, 1'b1, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
